// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issuing end of the serial divider handshake; one divide in flight, rd scoreboarded until writeback.
// Optional WAIT-phase watchdog is compiled in with `define DIV_WATCHDOG_EN.
module div_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_is_div,
    input  logic [1:0]  in_div_ctrl,
    input  logic [4:0]  in_rs1_idx,
    input  logic [4:0]  in_rs2_idx,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    output logic        div_accept,
    output logic        hazard_stall,
    output logic        div_req_valid,
    output logic [1:0]  div_req_ctrl,
    output logic [31:0] div_req_rs1,
    output logic [31:0] div_req_rs2,
    output logic [4:0]  div_req_rd,
    input  logic        div_done,
    output logic        div_busy,
    output logic        div_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_ctrl;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [4:0]  r_rd;
    logic        w_raw;
    logic        w_waw;
    logic        w_wd_hit;

    // x0 is never a real destination, so a pending rd of 0 never blocks anything.
    assign w_raw = (r_rd != 5'd0) && ((in_rs1_idx == r_rd) || (in_rs2_idx == r_rd));
    assign w_waw = (r_rd != 5'd0) && (in_rd == r_rd);

    always_comb begin
        w_state_nxt  = r_state;
        div_accept   = 1'b0;
        hazard_stall = 1'b0;
        if (in_valid && !flush) begin
            if (r_state == S_IDLE) div_accept   = in_is_div;
            else                   hazard_stall = in_is_div || w_raw || w_waw;
        end
        case (r_state)
            S_IDLE:  if (div_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: if (!stall)     w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (div_done)      w_state_nxt = S_DRAIN;
                else if (w_wd_hit) w_state_nxt = S_IDLE;
            end
            S_DRAIN: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ctrl  <= 2'd0;
            r_rs1   <= 32'd0;
            r_rs2   <= 32'd0;
            r_rd    <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            if (div_accept) begin
                r_ctrl <= in_div_ctrl;
                r_rs1  <= in_rs1_val;
                r_rs2  <= in_rs2_val;
                r_rd   <= in_rd;
            end
        end
    end

    assign div_req_valid = (r_state == S_ISSUE);
    assign div_req_ctrl  = r_ctrl;
    assign div_req_rs1   = r_rs1;
    assign div_req_rs2   = r_rs2;
    assign div_req_rd    = r_rd;
    assign div_busy      = (r_state != S_IDLE);

`ifdef DIV_WATCHDOG_EN
    logic [7:0] r_wd_cnt;
    logic       r_timeout;

    // Fires on the non-stalled WAIT cycle whose increment would make the count reach the limit.
    assign w_wd_hit = (r_state == S_WAIT) && !stall && !div_done
                      && (r_wd_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt  <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            if (flush || (r_state != S_WAIT)) r_wd_cnt <= 8'd0;
            else if (!stall)                  r_wd_cnt <= r_wd_cnt + 8'd1;
            if (w_wd_hit && !flush)           r_timeout <= 1'b1;
        end
    end

    assign div_timeout = r_timeout;
`else
    logic w_unused_timeout;

    assign w_wd_hit         = 1'b0;
    assign div_timeout      = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed protocol scenarios followed by random traffic, all checked against a transaction-level model.
module tb_div_issue_ctrl;

    localparam int TIMEOUT = 48;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, in_is_div, div_done;
    logic [1:0]  in_div_ctrl;
    logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd;
    logic [31:0] in_rs1_val, in_rs2_val;
    logic        div_accept, hazard_stall, div_req_valid, div_busy, div_timeout;
    logic [1:0]  div_req_ctrl;
    logic [31:0] div_req_rs1, div_req_rs2;
    logic [4:0]  div_req_rd;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one divide record with its lifecycle flags.
    logic        m_busy, m_issued, m_done, m_timeout;
    logic [1:0]  m_ctrl;
    logic [31:0] m_rs1, m_rs2;
    logic [4:0]  m_rd;
    int          m_cnt;

    // Snapshot of DUT outputs from the most recent tick.
    logic        s_accept, s_hazard, s_rv, s_busy, s_timeout;
    logic [31:0] s_rs1, s_rs2;
    logic [4:0]  s_rd;

    always #5 clk = ~clk;

    div_issue_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_is_div(in_is_div), .in_div_ctrl(in_div_ctrl),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd(in_rd),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .div_accept(div_accept), .hazard_stall(hazard_stall),
        .div_req_valid(div_req_valid), .div_req_ctrl(div_req_ctrl),
        .div_req_rs1(div_req_rs1), .div_req_rs2(div_req_rs2), .div_req_rd(div_req_rd),
        .div_done(div_done), .div_busy(div_busy), .div_timeout(div_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic d, input logic [1:0] c,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] r,
                         input logic [31:0] x, input logic [31:0] y);
        in_valid = v; in_is_div = d; in_div_ctrl = c;
        in_rs1_idx = a; in_rs2_idx = b; in_rd = r;
        in_rs1_val = x; in_rs2_val = y;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic tick();
        logic e_acc, e_haz, e_rv, dep;
        @(negedge clk);
        e_acc = !m_busy && in_valid && in_is_div && !flush;
        dep   = (m_rd != 5'd0) && (in_rs1_idx == m_rd || in_rs2_idx == m_rd || in_rd == m_rd);
        e_haz = m_busy && in_valid && !flush && (in_is_div || dep);
        e_rv  = m_busy && !m_issued;
        s_accept = div_accept; s_hazard = hazard_stall; s_rv = div_req_valid;
        s_busy = div_busy; s_timeout = div_timeout;
        s_rs1 = div_req_rs1; s_rs2 = div_req_rs2; s_rd = div_req_rd;
        chk("div_accept",    32'(div_accept),    32'(e_acc));
        chk("hazard_stall",  32'(hazard_stall),  32'(e_haz));
        chk("div_req_valid", 32'(div_req_valid), 32'(e_rv));
        chk("div_busy",      32'(div_busy),      32'(m_busy));
        chk("div_timeout",   32'(div_timeout),   32'(m_timeout));
        chk("div_req_ctrl",  32'(div_req_ctrl),  32'(m_ctrl));
        chk("div_req_rs1",   div_req_rs1,        m_rs1);
        chk("div_req_rs2",   div_req_rs2,        m_rs2);
        chk("div_req_rd",    32'(div_req_rd),    32'(m_rd));
        if (flush) begin
            m_busy = 1'b0; m_issued = 1'b0; m_done = 1'b0; m_cnt = 0;
        end else if (!m_busy) begin
            if (e_acc) begin
                m_busy = 1'b1; m_issued = 1'b0; m_done = 1'b0;
                m_ctrl = in_div_ctrl; m_rs1 = in_rs1_val; m_rs2 = in_rs2_val; m_rd = in_rd;
            end
        end else if (!m_issued) begin
            if (!stall) begin m_issued = 1'b1; m_cnt = 0; end
        end else if (!m_done) begin
            if (div_done) m_done = 1'b1;
`ifdef DIV_WATCHDOG_EN
            else if (!stall) begin
                m_cnt++;
                if (m_cnt == TIMEOUT) begin m_timeout = 1'b1; m_busy = 1'b0; end
            end
`endif
        end else begin
            m_busy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; div_done = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_busy = 1'b0; m_issued = 1'b0; m_done = 1'b0; m_timeout = 1'b0;
        m_ctrl = 2'd0; m_rs1 = 32'd0; m_rs2 = 32'd0; m_rd = 5'd0; m_cnt = 0;

        tick();
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_req_valid", 32'(s_rv), 32'd0);

        // DIVU 100/7 -> x5, full lifecycle.
        drive(1'b1, 1'b1, 2'b01, 5'd1, 5'd2, 5'd5, 32'd100, 32'd7);
        tick();
        chk("t1_accept", 32'(s_accept), 32'd1);
        idle();
        tick();
        chk("t1_req_valid", 32'(s_rv), 32'd1);
        chk("t1_rs1", s_rs1, 32'd100);
        chk("t1_rs2", s_rs2, 32'd7);
        chk("t1_rd", 32'(s_rd), 32'd5);
        repeat (34) tick();
        chk("t1_busy_wait", 32'(s_busy), 32'd1);
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        tick();
        chk("t1_busy_drain", 32'(s_busy), 32'd1);
        tick();
        chk("t1_idle", 32'(s_busy), 32'd0);

        // Request held under stall.
        drive(1'b1, 1'b1, 2'b10, 5'd1, 5'd2, 5'd3, 32'd20, 32'd4);
        tick();
        idle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_req_held", 32'(s_rv), 32'd1);
            chk("t2_rs1_held", s_rs1, 32'd20);
        end
        stall = 1'b0;
        tick();
        chk("t2_req_4th", 32'(s_rv), 32'd1);
        tick();
        chk("t2_wait_req", 32'(s_rv), 32'd0);
        div_done = 1'b1; tick(); div_done = 1'b0;
        tick(); tick();

        // Hazards against pending rd=5.
        drive(1'b1, 1'b1, 2'b00, 5'd1, 5'd2, 5'd5, 32'd9, 32'd3);
        tick();
        idle();
        tick();
        drive(1'b1, 1'b0, 2'd0, 5'd5, 5'd1, 5'd9, 32'd0, 32'd0);
        tick();
        chk("t3_raw", 32'(s_hazard), 32'd1);
        drive(1'b1, 1'b0, 2'd0, 5'd6, 5'd8, 5'd7, 32'd0, 32'd0);
        tick();
        chk("t3_indep", 32'(s_hazard), 32'd0);
        drive(1'b1, 1'b1, 2'd0, 5'd6, 5'd8, 5'd7, 32'd0, 32'd0);
        tick();
        chk("t3_second_div", 32'(s_hazard), 32'd1);
        chk("t3_no_accept", 32'(s_accept), 32'd0);
        drive(1'b1, 1'b0, 2'd0, 5'd1, 5'd2, 5'd5, 32'd0, 32'd0);
        tick();
        chk("t3_waw", 32'(s_hazard), 32'd1);
        idle();
        div_done = 1'b1; tick(); div_done = 1'b0;
        drive(1'b1, 1'b0, 2'd0, 5'd1, 5'd5, 5'd9, 32'd0, 32'd0);
        tick();
        chk("t3_drain_raw", 32'(s_hazard), 32'd1);
        idle();
        tick();

        // rd=0 never hazards; then flush coincident with done.
        drive(1'b1, 1'b1, 2'b11, 5'd2, 5'd3, 5'd0, 32'd50, 32'd5);
        tick();
        idle();
        tick();
        drive(1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("t4_rd0", 32'(s_hazard), 32'd0);
        flush = 1'b1; div_done = 1'b1;
        tick();
        chk("t5_flush_haz", 32'(s_hazard), 32'd0);
        flush = 1'b0; div_done = 1'b0;
        drive(1'b1, 1'b1, 2'b00, 5'd1, 5'd2, 5'd4, 32'd77, 32'd11);
        tick();
        chk("t5_busy_after", 32'(s_busy), 32'd0);
        chk("t5_accept_after", 32'(s_accept), 32'd1);
        idle();
        tick(); tick();
        div_done = 1'b1; tick(); div_done = 1'b0;
        tick(); tick();

        // Withheld div_done.
        drive(1'b1, 1'b1, 2'b01, 5'd1, 5'd2, 5'd6, 32'd1, 32'd0);
        tick();
        idle();
        tick();
        repeat (47) tick();
        chk("t6_pre_busy", 32'(s_busy), 32'd1);
        chk("t6_pre_timeout", 32'(s_timeout), 32'd0);
        tick();
        tick();
`ifdef DIV_WATCHDOG_EN
        chk("t6_timeout", 32'(s_timeout), 32'd1);
        chk("t6_idle", 32'(s_busy), 32'd0);
`else
        chk("t6_timeout", 32'(s_timeout), 32'd0);
        chk("t6_waiting", 32'(s_busy), 32'd1);
`endif
        div_done = 1'b1; tick(); div_done = 1'b0;
        tick(); tick();

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom, $urandom);
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            div_done = ($urandom_range(0, 11) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
